mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/arb_starve_counter.sv | 35 +++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned DEFAULT_WORD_SIZE    = 16;
    localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_D = 2'd1,
        LOCK_I = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the arbiter: fetch port, data port and shared memory port.
interface mem_port_arbiter_if #(
    parameter int unsigned WORD_SIZE = 16
);
    logic                 InstrRead;
    logic [WORD_SIZE-1:0] InstrAddr;
    logic [WORD_SIZE-1:0] InstrIn;
    logic                 InstrValid;
    logic                 InstrWaitreq;

    logic                 ReadData;
    logic                 WriteData;
    logic [WORD_SIZE-1:0] DataAddr;
    logic [WORD_SIZE-1:0] DataOut;
    logic [WORD_SIZE-1:0] DataIn;
    logic                 DataValid;
    logic                 DataWaitreq;

    logic [WORD_SIZE-1:0] MemAddr;
    logic [WORD_SIZE-1:0] MemWdata;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 MemWaitreq;
    logic [WORD_SIZE-1:0] MemRdata;

    // Arbiter view.
    modport slave (
        input  InstrRead, InstrAddr, ReadData, WriteData, DataAddr, DataOut,
               MemWaitreq, MemRdata,
        output InstrIn, InstrValid, InstrWaitreq, DataIn, DataValid, DataWaitreq,
               MemAddr, MemWdata, MemRead, MemWrite
    );

    // Requesters and memory view.
    modport master (
        output InstrRead, InstrAddr, ReadData, WriteData, DataAddr, DataOut,
               MemWaitreq, MemRdata,
        input  InstrIn, InstrValid, InstrWaitreq, DataIn, DataValid, DataWaitreq,
               MemAddr, MemWdata, MemRead, MemWrite
    );
endinterface

// File: rtl/arb_starve_counter.sv
// Counts consecutive data grants while a fetch is waiting; saturates at STARVE_LIMIT.
module arb_starve_counter #(
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             instr_req_i,
    input  logic             instr_acc_i,
    input  logic             data_acc_i,
    output logic [CNT_W-1:0] cnt_o
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!instr_req_i || instr_acc_i) begin
            cnt_d = '0;
        end else if (data_acc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory, with
// wait-state locking and a starvation guard for the fetch side.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = DEFAULT_WORD_SIZE,
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input logic              Clock,
    input logic              Resetn,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t       state_q, state_d;
    arb_owner_t       owner;
    arb_owner_t       ret_owner_q, ret_owner_d;
    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             data_req;
    logic             accept;
    logic             read_accept;

    assign data_req    = bus.ReadData | bus.WriteData;
    assign starved     = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign accept      = (owner != OWN_NONE) && !bus.MemWaitreq;
    assign read_accept = accept && ((owner == OWN_I) || ((owner == OWN_D) && !bus.WriteData));

    // Owner: a locked side keeps the port; otherwise decided fresh every cycle.
    always_comb begin
        owner = OWN_NONE;
        case (state_q)
            LOCK_D:  owner = OWN_D;
            LOCK_I:  owner = OWN_I;
            default: begin
                if (data_req && (!starved || !bus.InstrRead)) begin
                    owner = OWN_D;
                end else if (bus.InstrRead) begin
                    owner = OWN_I;
                end
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            ret_owner_q <= OWN_NONE;
        end else begin
            state_q     <= state_d;
            ret_owner_q <= ret_owner_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ret_owner_d = read_accept ? owner : OWN_NONE;
        case (state_q)
            IDLE: begin
                if (bus.MemWaitreq && (owner == OWN_D)) begin
                    state_d = LOCK_D;
                end else if (bus.MemWaitreq && (owner == OWN_I)) begin
                    state_d = LOCK_I;
                end
            end
            LOCK_D, LOCK_I: begin
                if (!bus.MemWaitreq) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.MemAddr  = '0;
        bus.MemWdata = '0;
        case (owner)
            OWN_I: begin
                bus.MemRead = 1'b1;
                bus.MemAddr = bus.InstrAddr;
            end
            OWN_D: begin
                bus.MemWrite = bus.WriteData;
                bus.MemRead  = bus.ReadData & ~bus.WriteData;
                bus.MemAddr  = bus.DataAddr;
                bus.MemWdata = bus.DataOut;
            end
            default: ;
        endcase

        bus.InstrWaitreq = (owner == OWN_I) ? bus.MemWaitreq : bus.InstrRead;
        bus.DataWaitreq  = (owner == OWN_D) ? bus.MemWaitreq : data_req;

        // Return path is gated by reset so a stale pending owner never leaks out.
        bus.InstrValid = Resetn && (ret_owner_q == OWN_I);
        bus.DataValid  = Resetn && (ret_owner_q == OWN_D);
        bus.InstrIn    = bus.InstrValid ? bus.MemRdata : '0;
        bus.DataIn     = bus.DataValid ? bus.MemRdata : '0;
    end

    arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk_i      (Clock),
        .rst_ni     (Resetn),
        .instr_req_i(bus.InstrRead),
        .instr_acc_i(accept && (owner == OWN_I)),
        .data_acc_i (accept && (owner == OWN_D)),
        .cnt_o      (starve_cnt)
    );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a cycle-level reference model of the arbitration rules.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned W     = 16;
    localparam int          LIMIT = 4;

    logic Clock;
    logic Resetn;
    int   checks;
    int   errors;

    mem_port_arbiter_if #(.WORD_SIZE(W)) bus ();

    mem_port_arbiter #(
        .WORD_SIZE   (W),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.InstrRead  = 1'b0;
        bus.InstrAddr  = '0;
        bus.ReadData   = 1'b0;
        bus.WriteData  = 1'b0;
        bus.DataAddr   = '0;
        bus.DataOut    = '0;
        bus.MemWaitreq = 1'b0;
        bus.MemRdata   = '0;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        idle_inputs();
        bus.MemRdata = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if ({bus.InstrValid, bus.DataValid, bus.InstrIn, bus.DataIn} !== 34'd0) begin
                errors++;
                $display("FAIL reset_during: valid/data=%h expected 0",
                         {bus.InstrValid, bus.DataValid, bus.InstrIn, bus.DataIn});
            end
            tick();
        end
        Resetn = 1'b1;
        #2;
        checks++;
        if ({bus.InstrValid, bus.DataValid, bus.InstrIn, bus.DataIn,
             bus.MemRead, bus.MemWrite, bus.MemAddr, bus.MemWdata} !== 68'd0) begin
            errors++;
            $display("FAIL reset_after: outputs not idle (valids %b%b mem %b%b %h %h)",
                     bus.InstrValid, bus.DataValid, bus.MemRead, bus.MemWrite,
                     bus.MemAddr, bus.MemWdata);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected IDLE", dut.state_q);
        end
        bus.MemRdata = '0;
        tick();
    endtask

    task automatic test_instr_only();
        idle_inputs();
        bus.InstrRead = 1'b1;
        bus.InstrAddr = 16'h0010;
        #2;
        checks++;
        if ({bus.MemRead, bus.MemWrite, bus.MemAddr, bus.InstrWaitreq, bus.DataWaitreq} !==
            {1'b1, 1'b0, 16'h0010, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL instr_req: rd=%b wr=%b addr=%h iw=%b dw=%b expected 1 0 0010 0 0",
                     bus.MemRead, bus.MemWrite, bus.MemAddr, bus.InstrWaitreq, bus.DataWaitreq);
        end
        tick();
        bus.InstrRead = 1'b0;
        bus.MemRdata  = 16'hA5A5;
        #2;
        checks++;
        if ({bus.InstrValid, bus.InstrIn, bus.DataValid, bus.DataIn} !==
            {1'b1, 16'hA5A5, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL instr_return: iv=%b in=%h dv=%b din=%h expected 1 a5a5 0 0000",
                     bus.InstrValid, bus.InstrIn, bus.DataValid, bus.DataIn);
        end
        tick();
        bus.MemRdata = '0;
    endtask

    task automatic test_collision();
        idle_inputs();
        bus.InstrRead = 1'b1;
        bus.InstrAddr = 16'h0100;
        bus.ReadData  = 1'b1;
        bus.DataAddr  = 16'h0200;
        #2;
        checks++;
        if ({bus.MemRead, bus.MemAddr, bus.InstrWaitreq, bus.DataWaitreq} !==
            {1'b1, 16'h0200, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL collision_grant: rd=%b addr=%h iw=%b dw=%b expected 1 0200 1 0",
                     bus.MemRead, bus.MemAddr, bus.InstrWaitreq, bus.DataWaitreq);
        end
        tick();
        bus.ReadData = 1'b0;
        bus.MemRdata = 16'hBEEF;
        #2;
        checks++;
        if ({bus.MemAddr, bus.InstrWaitreq, bus.DataValid, bus.DataIn, bus.InstrValid} !==
            {16'h0100, 1'b0, 1'b1, 16'hBEEF, 1'b0}) begin
            errors++;
            $display("FAIL collision_next: addr=%h iw=%b dv=%b din=%h iv=%b expected 0100 0 1 beef 0",
                     bus.MemAddr, bus.InstrWaitreq, bus.DataValid, bus.DataIn, bus.InstrValid);
        end
        tick();
        bus.InstrRead = 1'b0;
        bus.MemRdata  = 16'h1111;
        #2;
        checks++;
        if ({bus.InstrValid, bus.InstrIn, bus.DataValid} !== {1'b1, 16'h1111, 1'b0}) begin
            errors++;
            $display("FAIL collision_instr_ret: iv=%b in=%h dv=%b expected 1 1111 0",
                     bus.InstrValid, bus.InstrIn, bus.DataValid);
        end
        tick();
        bus.MemRdata = '0;
    endtask

    task automatic test_lock();
        idle_inputs();
        bus.InstrRead  = 1'b1;
        bus.InstrAddr  = 16'h0100;
        bus.WriteData  = 1'b1;
        bus.DataAddr   = 16'h0300;
        bus.DataOut    = 16'h1234;
        bus.MemWaitreq = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) bus.MemWaitreq = 1'b0;
            #2;
            checks++;
            if ({bus.MemWrite, bus.MemRead, bus.MemAddr, bus.MemWdata,
                 bus.InstrWaitreq, bus.DataWaitreq} !==
                {1'b1, 1'b0, 16'h0300, 16'h1234, 1'b1, (c != 3)}) begin
                errors++;
                $display("FAIL lock_cycle%0d: wr=%b rd=%b addr=%h wd=%h iw=%b dw=%b",
                         c, bus.MemWrite, bus.MemRead, bus.MemAddr, bus.MemWdata,
                         bus.InstrWaitreq, bus.DataWaitreq);
            end
            if (c != 0) begin
                checks++;
                if (dut.state_q !== LOCK_D) begin
                    errors++;
                    $display("FAIL lock_state%0d: got %0d expected LOCK_D", c, dut.state_q);
                end
            end
            tick();
        end
        bus.WriteData = 1'b0;
        #2;
        checks++;
        if ({bus.MemRead, bus.MemAddr, bus.InstrWaitreq, bus.DataValid} !==
            {1'b1, 16'h0100, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL lock_release: rd=%b addr=%h iw=%b dv=%b expected 1 0100 0 0",
                     bus.MemRead, bus.MemAddr, bus.InstrWaitreq, bus.DataValid);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_starvation();
        idle_inputs();
        bus.InstrRead = 1'b1;
        bus.InstrAddr = 16'h0400;
        bus.ReadData  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.DataAddr = 16'h0800 + 16'(c);
            #2;
            checks++;
            if (c < LIMIT) begin
                if ({bus.MemAddr, bus.InstrWaitreq, bus.DataWaitreq} !==
                    {16'h0800 + 16'(c), 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL starve_data%0d: addr=%h iw=%b dw=%b", c,
                             bus.MemAddr, bus.InstrWaitreq, bus.DataWaitreq);
                end
            end else begin
                if ({bus.MemAddr, bus.InstrWaitreq, bus.DataWaitreq} !==
                    {16'h0400, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL starve_instr: addr=%h iw=%b dw=%b expected 0400 0 1",
                             bus.MemAddr, bus.InstrWaitreq, bus.DataWaitreq);
                end
            end
            if (c == LIMIT) begin
                checks++;
                if (dut.starve_cnt !== 3'(LIMIT)) begin
                    errors++;
                    $display("FAIL starve_cnt_sat: got %0d expected %0d", dut.starve_cnt, LIMIT);
                end
            end
            tick();
        end
        checks++;
        if (dut.starve_cnt !== 3'd0) begin
            errors++;
            $display("FAIL starve_cnt_clear: got %0d expected 0", dut.starve_cnt);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_lock();
        idle_inputs();
        bus.InstrRead  = 1'b1;
        bus.InstrAddr  = 16'h0500;
        bus.MemWaitreq = 1'b1;
        tick();
        checks++;
        if (dut.state_q !== LOCK_I) begin
            errors++;
            $display("FAIL rml_lock: got %0d expected LOCK_I", dut.state_q);
        end
        bus.MemWaitreq = 1'b0;
        Resetn = 1'b0;
        #2;
        checks++;
        if ({bus.MemRead, bus.MemAddr, bus.InstrWaitreq} !== {1'b1, 16'h0500, 1'b0}) begin
            errors++;
            $display("FAIL rml_accept: rd=%b addr=%h iw=%b expected 1 0500 0",
                     bus.MemRead, bus.MemAddr, bus.InstrWaitreq);
        end
        tick();
        Resetn = 1'b1;
        bus.InstrRead = 1'b0;
        bus.MemRdata  = 16'h7777;
        #2;
        checks++;
        if ({bus.InstrValid, bus.InstrIn, bus.DataValid, bus.DataIn,
             bus.MemRead, bus.MemWrite, bus.MemAddr} !== 52'd0) begin
            errors++;
            $display("FAIL rml_after: iv=%b in=%h dv=%b din=%h rd=%b wr=%b addr=%h expected all 0",
                     bus.InstrValid, bus.InstrIn, bus.DataValid, bus.DataIn,
                     bus.MemRead, bus.MemWrite, bus.MemAddr);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL rml_state: got %0d expected IDLE", dut.state_q);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_read_write_both();
        idle_inputs();
        bus.ReadData  = 1'b1;
        bus.WriteData = 1'b1;
        bus.DataAddr  = 16'h0040;
        bus.DataOut   = 16'h00AB;
        #2;
        checks++;
        if ({bus.MemWrite, bus.MemRead, bus.MemAddr, bus.MemWdata} !==
            {1'b1, 1'b0, 16'h0040, 16'h00AB}) begin
            errors++;
            $display("FAIL rw_both: wr=%b rd=%b addr=%h wd=%h expected 1 0 0040 00ab",
                     bus.MemWrite, bus.MemRead, bus.MemAddr, bus.MemWdata);
        end
        tick();
        idle_inputs();
        bus.MemRdata = 16'h5555;
        #2;
        checks++;
        if ({bus.DataValid, bus.DataIn, bus.InstrValid} !== 18'd0) begin
            errors++;
            $display("FAIL rw_no_valid: dv=%b din=%h iv=%b expected 0 0000 0",
                     bus.DataValid, bus.DataIn, bus.InstrValid);
        end
        tick();
        bus.MemRdata = '0;
    endtask

    // Reference model: 0 = nobody, 1 = fetch, 2 = data.
    task automatic test_random();
        int        lock, cnt, ret, own;
        bit        ihold, dhold, acc, isread, dreq;
        bit [1:0]  r;
        logic [33:0] exp_mem;
        logic [1:0]  exp_wait;
        logic [33:0] exp_ret;

        Resetn = 1'b0;
        idle_inputs();
        tick();
        Resetn = 1'b1;
        lock = 0; cnt = 0; ret = 0;
        ihold = 0; dhold = 0;
        for (int i = 0; i < 600; i++) begin
            if (!ihold) begin
                bus.InstrRead = ($urandom_range(0, 2) != 0);
                bus.InstrAddr = 16'($urandom);
            end
            if (!dhold) begin
                r = 2'($urandom_range(0, 3));
                bus.ReadData  = r[0];
                bus.WriteData = r[1];
                bus.DataAddr  = 16'($urandom);
                bus.DataOut   = 16'($urandom);
            end
            bus.MemWaitreq = ($urandom_range(0, 2) == 0);
            bus.MemRdata   = 16'($urandom);
            Resetn         = ($urandom_range(0, 39) != 0);
            #2;

            dreq = bus.ReadData || bus.WriteData;
            if (lock != 0)                                   own = lock;
            else if (dreq && (cnt < LIMIT || !bus.InstrRead)) own = 2;
            else if (bus.InstrRead)                          own = 1;
            else                                             own = 0;

            if (own == 1)      exp_mem = {1'b1, 1'b0, bus.InstrAddr, 16'h0000};
            else if (own == 2) exp_mem = {!bus.WriteData, bus.WriteData, bus.DataAddr, bus.DataOut};
            else               exp_mem = '0;
            exp_wait = {(own == 1) ? bus.MemWaitreq : bus.InstrRead,
                        (own == 2) ? bus.MemWaitreq : dreq};
            exp_ret = '0;
            if (Resetn && ret == 1) exp_ret = {1'b1, 1'b0, bus.MemRdata, 16'h0000};
            if (Resetn && ret == 2) exp_ret = {1'b0, 1'b1, 16'h0000, bus.MemRdata};

            checks++;
            if ({bus.MemRead, bus.MemWrite, bus.MemAddr, bus.MemWdata} !== exp_mem) begin
                errors++;
                $display("FAIL rand_mem cycle %0d: got %h expected %h", i,
                         {bus.MemRead, bus.MemWrite, bus.MemAddr, bus.MemWdata}, exp_mem);
            end
            checks++;
            if ({bus.InstrWaitreq, bus.DataWaitreq} !== exp_wait) begin
                errors++;
                $display("FAIL rand_waitreq cycle %0d: got %b expected %b", i,
                         {bus.InstrWaitreq, bus.DataWaitreq}, exp_wait);
            end
            checks++;
            if ({bus.InstrValid, bus.DataValid, bus.InstrIn, bus.DataIn} !== exp_ret) begin
                errors++;
                $display("FAIL rand_return cycle %0d: got %h expected %h", i,
                         {bus.InstrValid, bus.DataValid, bus.InstrIn, bus.DataIn}, exp_ret);
            end

            acc    = (own != 0) && !bus.MemWaitreq;
            isread = (own == 1) || (own == 2 && !bus.WriteData);
            ihold  = bus.InstrRead && !(acc && own == 1);
            dhold  = dreq && !(acc && own == 2);
            if (!Resetn) begin
                lock = 0; cnt = 0; ret = 0;
            end else begin
                lock = (own != 0 && bus.MemWaitreq) ? own : 0;
                ret  = (acc && isread) ? own : 0;
                if (!bus.InstrRead || (acc && own == 1)) cnt = 0;
                else if (acc && own == 2 && cnt < LIMIT) cnt = cnt + 1;
            end
            tick();
        end
        Resetn = 1'b1;
        idle_inputs();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Resetn = 1'b0;
        idle_inputs();
        test_reset();
        test_instr_only();
        test_collision();
        test_lock();
        test_starvation();
        test_reset_mid_lock();
        test_read_write_both();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
